// File: rtl/unit_clause_writer.sv
// rtl/unit_clause_writer.sv - batches BCP unit clauses and writes them to the unit_clause register
// Optional statistics counters are enabled with `define UNIT_WRITER_STATS_EN.
module unit_clause_writer #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clause_valid,
    output logic          clause_ready,
    input  logic          clause_last,
    input  logic          clause_sat,
    input  logic [W-1:0]  clause_free,
    input  logic [W-1:0]  clause_pol,
    input  logic          wr_ready,
    output logic          w_en,
    output logic [W-1:0]  wd,
    output logic [W-1:0]  wpol,
    output logic          batch_done,
    output logic          conflict,
    output logic [W-1:0]  conflict_var,
    output logic [CW-1:0] unit_cnt
`ifdef UNIT_WRITER_STATS_EN
    ,
    output logic [15:0]   tot_units,
    output logic [15:0]   tot_conflicts
`endif
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] FLUSH   = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;

    logic [1:0]   state;
    logic         started;
    logic [W-1:0] unit_mask;
    logic [W-1:0] pol_mask;
    logic         conf_flag;

    logic any_free;
    logic multi_free;
    logic is_unit;
    logic is_empty;
    logic pending;
    logic same_pol;
    logic accept;

    // Only need to distinguish zero, one, or more free literals.
    always_comb begin
        any_free   = 1'b0;
        multi_free = 1'b0;
        for (int i = 0; i < W; i++) begin
            multi_free = multi_free | (any_free & clause_free[i]);
            any_free   = any_free | clause_free[i];
        end
    end

    assign is_unit  = !clause_sat && any_free && !multi_free;
    assign is_empty = !clause_sat && !any_free;
    assign pending  = |(unit_mask & clause_free);
    assign same_pol = ((pol_mask ^ clause_pol) & clause_free) == '0;
    assign accept   = clause_valid && clause_ready;

    assign clause_ready = started && (state == COLLECT);
    assign w_en         = (state == FLUSH) && wr_ready && !conf_flag && (unit_mask != '0);
    assign wd           = w_en ? unit_mask : '0;
    assign wpol         = w_en ? pol_mask : '0;
    assign batch_done   = (state == REPORT);
    assign conflict     = batch_done && conf_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= COLLECT;
            started      <= 1'b0;
            unit_mask    <= '0;
            pol_mask     <= '0;
            conf_flag    <= 1'b0;
            conflict_var <= '0;
            unit_cnt     <= '0;
        end else begin
            started <= 1'b1;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (is_unit) begin
                            if (!pending) begin
                                unit_mask <= unit_mask | clause_free;
                                pol_mask  <= pol_mask | (clause_pol & clause_free);
                                if (unit_cnt != {CW{1'b1}}) begin
                                    unit_cnt <= unit_cnt + CW'(1);
                                end
                            end else if (!same_pol) begin
                                conf_flag <= 1'b1;
                                // A recorded var is never zero, so zero means no polarity conflict yet.
                                if (conflict_var == '0) begin
                                    conflict_var <= clause_free;
                                end
                            end
                        end
                        if (is_empty) begin
                            conf_flag <= 1'b1;
                        end
                        if (clause_last) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (conf_flag || (unit_mask == '0) || wr_ready) begin
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    unit_mask    <= '0;
                    pol_mask     <= '0;
                    conf_flag    <= 1'b0;
                    conflict_var <= '0;
                    unit_cnt     <= '0;
                    state        <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

`ifdef UNIT_WRITER_STATS_EN
    logic [15:0] wd_pop;
    logic [16:0] units_sum;

    always_comb begin
        wd_pop = '0;
        for (int i = 0; i < W; i++) begin
            wd_pop = wd_pop + 16'(wd[i]);
        end
        units_sum = {1'b0, tot_units} + {1'b0, wd_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_units     <= '0;
            tot_conflicts <= '0;
        end else begin
            if (w_en) begin
                tot_units <= units_sum[16] ? 16'hffff : units_sum[15:0];
            end
            if (conflict && (tot_conflicts != 16'hffff)) begin
                tot_conflicts <= tot_conflicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_unit_clause_writer.sv
// tb/tb_unit_clause_writer.sv - table-driven bench for unit_clause_writer
module tb_unit_clause_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clause_valid, clause_ready, clause_last, clause_sat;
    logic [3:0] clause_free, clause_pol;
    logic       wr_ready, w_en, batch_done, conflict;
    logic [3:0] wd, wpol, conflict_var;
    logic [7:0] unit_cnt;
`ifdef UNIT_WRITER_STATS_EN
    logic [15:0] tot_units, tot_conflicts;
`endif

    unit_clause_writer #(.W(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .clause_valid(clause_valid), .clause_ready(clause_ready), .clause_last(clause_last),
        .clause_sat(clause_sat), .clause_free(clause_free), .clause_pol(clause_pol),
        .wr_ready(wr_ready), .w_en(w_en), .wd(wd), .wpol(wpol),
        .batch_done(batch_done), .conflict(conflict), .conflict_var(conflict_var),
        .unit_cnt(unit_cnt)
`ifdef UNIT_WRITER_STATS_EN
        , .tot_units(tot_units), .tot_conflicts(tot_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sat;
        logic [3:0] free;
        logic [3:0] pol;
        logic       last;
    } clause_t;

    typedef struct {
        string      name;
        int         stall;
        logic       exp_wen;
        logic [3:0] exp_wd;
        logic [3:0] exp_wpol;
        logic [7:0] exp_cnt;
        logic       exp_conf;
        logic [3:0] exp_cvar;
    } batch_t;

    clause_t cl[27];
    batch_t  bt[13];
    int      cptr = 0;
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic sat, input logic [3:0] free, input logic [3:0] pol, input logic last);
        int n = 0;
        bit got = 0;
        clause_sat = sat; clause_free = free; clause_pol = pol; clause_last = last;
        clause_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk);
            if (clause_ready) got = 1;
            @(posedge clk);
            #1;
            n++;
        end
        clause_valid = 1'b0; clause_last = 1'b0;
        if (!got) check("clause_ready_timeout", 0, 1);
    endtask

    task automatic run_batch(input int b);
        int cyc, wen_cnt, wen_cyc, done_cyc;
        logic [3:0] got_wd, got_wpol, got_cvar;
        logic got_conf, zero_leak, ready_leak, conf_leak;
        bit last_sent;
        batch_t v;
        v = bt[b];
        last_sent = 0;
        while (!last_sent) begin
            send(cl[cptr].sat, cl[cptr].free, cl[cptr].pol, cl[cptr].last);
            last_sent = cl[cptr].last;
            cptr++;
        end
        cyc = 0; wen_cnt = 0; wen_cyc = -1; done_cyc = -1;
        got_wd = 0; got_wpol = 0; got_cvar = 0; got_conf = 0;
        zero_leak = 0; ready_leak = 0; conf_leak = 0;
        wr_ready = (v.stall == 0);
        while (done_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            if (cyc == 0) check($sformatf("%s unit_cnt", v.name), unit_cnt, v.exp_cnt);
            if (clause_ready) ready_leak = 1;
            if (w_en) begin
                wen_cnt++; wen_cyc = cyc; got_wd = wd; got_wpol = wpol;
            end else if (wd != 0 || wpol != 0) zero_leak = 1;
            if (batch_done) begin
                done_cyc = cyc; got_conf = conflict; got_cvar = conflict_var;
            end else if (conflict) conf_leak = 1;
            @(posedge clk);
            #1;
            cyc++;
            wr_ready = (cyc >= v.stall);
        end
        check($sformatf("%s w_en_count", v.name), wen_cnt, {31'd0, v.exp_wen});
        if (v.exp_wen) begin
            check($sformatf("%s w_en_cycle", v.name), wen_cyc, v.stall);
            check($sformatf("%s wd", v.name), got_wd, v.exp_wd);
            check($sformatf("%s wpol", v.name), got_wpol, v.exp_wpol);
        end
        check($sformatf("%s batch_done_cycle", v.name), done_cyc, v.exp_wen ? v.stall + 1 : 1);
        check($sformatf("%s conflict", v.name), got_conf, v.exp_conf);
        check($sformatf("%s conflict_var", v.name), got_cvar, v.exp_cvar);
        check($sformatf("%s wd_zero_when_idle", v.name), zero_leak, 0);
        check($sformatf("%s ready_low_after_last", v.name), ready_leak, 0);
        check($sformatf("%s conflict_only_with_done", v.name), conf_leak, 0);
        @(negedge clk);
        check($sformatf("%s cleared", v.name), {clause_ready, unit_cnt, conflict_var}, {1'b1, 8'd0, 4'd0});
    endtask

    initial begin
        // clause table: sat, free, pol, last
        cl[0]  = '{0, 4'b0010, 4'b0010, 0}; cl[1]  = '{0, 4'b1000, 4'b0000, 1};
        cl[2]  = '{0, 4'b0010, 4'b0010, 0}; cl[3]  = '{0, 4'b1000, 4'b0000, 1};
        cl[4]  = '{0, 4'b0010, 4'b0010, 0}; cl[5]  = '{0, 4'b0010, 4'b0000, 1};
        cl[6]  = '{0, 4'b0000, 4'b0000, 1};
        cl[7]  = '{1, 4'b0000, 4'b0000, 1};
        cl[8]  = '{0, 4'b0011, 4'b0011, 0}; cl[9]  = '{1, 4'b0100, 4'b0100, 1};
        cl[10] = '{0, 4'b0100, 4'b0100, 0}; cl[11] = '{0, 4'b0100, 4'b0100, 1};
        cl[12] = '{0, 4'b0100, 4'b1111, 1};
        cl[13] = '{0, 4'b0000, 4'b0000, 0}; cl[14] = '{0, 4'b0001, 4'b0001, 0};
        cl[15] = '{0, 4'b0001, 4'b0000, 1};
        cl[16] = '{0, 4'b0001, 4'b0001, 0}; cl[17] = '{0, 4'b1000, 4'b1000, 0};
        cl[18] = '{0, 4'b0001, 4'b0000, 0}; cl[19] = '{0, 4'b1000, 4'b0000, 1};
        cl[20] = '{0, 4'b0001, 4'b0001, 0}; cl[21] = '{0, 4'b0010, 4'b0000, 0};
        cl[22] = '{0, 4'b0100, 4'b0100, 0}; cl[23] = '{0, 4'b1000, 4'b1000, 1};
        cl[24] = '{0, 4'b0001, 4'b0001, 0}; cl[25] = '{1, 4'b0001, 4'b0000, 1};
        cl[26] = '{0, 4'b0001, 4'b0001, 1};
        // batch table: name, stall, wen, wd, wpol, cnt, conflict, conflict_var
        bt[0]  = '{"two_units",      0, 1, 4'b1010, 4'b0010, 8'd2, 0, 4'b0000};
        bt[1]  = '{"two_units_stall", 5, 1, 4'b1010, 4'b0010, 8'd2, 0, 4'b0000};
        bt[2]  = '{"pol_conflict",   0, 0, 4'b0000, 4'b0000, 8'd1, 1, 4'b0010};
        bt[3]  = '{"empty_clause",   0, 0, 4'b0000, 4'b0000, 8'd0, 1, 4'b0000};
        bt[4]  = '{"empty_sat",      0, 0, 4'b0000, 4'b0000, 8'd0, 0, 4'b0000};
        bt[5]  = '{"no_units",       0, 0, 4'b0000, 4'b0000, 8'd0, 0, 4'b0000};
        bt[6]  = '{"duplicate",      0, 1, 4'b0100, 4'b0100, 8'd1, 0, 4'b0000};
        bt[7]  = '{"pol_masked",     0, 1, 4'b0100, 4'b0100, 8'd1, 0, 4'b0000};
        bt[8]  = '{"empty_then_pol", 0, 0, 4'b0000, 4'b0000, 8'd1, 1, 4'b0001};
        bt[9]  = '{"first_conflict", 0, 0, 4'b0000, 4'b0000, 8'd2, 1, 4'b0001};
        bt[10] = '{"all_vars",       2, 1, 4'b1111, 4'b1101, 8'd4, 0, 4'b0000};
        bt[11] = '{"sat_opposite",   0, 1, 4'b0001, 4'b0001, 8'd1, 0, 4'b0000};
        bt[12] = '{"after_reset",    0, 1, 4'b0001, 4'b0001, 8'd1, 0, 4'b0000};

        rst_n = 1'b0; clause_valid = 0; clause_last = 0; clause_sat = 0;
        clause_free = 0; clause_pol = 0; wr_ready = 0;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", {clause_ready, w_en, wd, wpol, batch_done, conflict, conflict_var, unit_cnt}, 0);
        end
        rst_n = 1'b1;
        #1 check("ready_low_before_first_edge", clause_ready, 0);
        @(posedge clk);
        #1 check("ready_high_after_first_edge", clause_ready, 1);

        for (int b = 0; b < 12; b++) run_batch(b);

        send(0, 4'b0001, 4'b0001, 0);
        send(0, 4'b0010, 4'b0010, 0);
        rst_n = 1'b0;
        wr_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_batch_reset_quiet", {w_en, batch_done, clause_ready, unit_cnt}, 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_batch(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
